puzzle3_1_joltage_acc: RTL and testbench

- Streaming accumulator for battery banks, one decimal digit per clock.
- For each bank it finds the largest two-digit value formed by choosing two digits in order: tens digit earlier in the bank, units digit later.
- Adds that per-bank maximum into a running total.
- Sits behind a character-parsing front end that delivers digits already converted from ASCII, plus an end-of-bank marker.

---
 rtl/puzzle3_1_joltage_acc.sv | 67 ++++++
 tb/tb_puzzle3_1_joltage_acc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/puzzle3_1_joltage_acc.sv
// Streaming battery-bank accumulator: per bank, keeps the largest ordered two-digit value and adds it to sum.
// Optional macro PUZZLE3_BANK_CNT_EN adds the bank_cnt output counting completed banks.
module puzzle3_1_joltage_acc #(
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       data_in,
  input  logic             wr_en,
  input  logic             bank_end,
`ifdef PUZZLE3_BANK_CNT_EN
  output logic [SUM_W-1:0] sum,
  output logic [15:0]      bank_cnt
`else
  output logic [SUM_W-1:0] sum
`endif
);

  logic [3:0] max_digit;
  logic       have_digit;
  logic [6:0] best;

  logic       accept;
  logic       close_bank;
  logic [6:0] cand;
  logic [6:0] best_next;
  logic [3:0] max_digit_next;

  // Out-of-range digits are dropped entirely, including their bank_end qualifier.
  always_comb begin
    accept         = wr_en && (data_in <= 4'd9);
    close_bank     = accept && bank_end;
    cand           = 7'd0;
    if (have_digit)
      cand = ({3'b000, max_digit} * 7'd10) + {3'b000, data_in};
    best_next      = (cand > best) ? cand : best;
    max_digit_next = (data_in > max_digit) ? data_in : max_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_digit  <= 4'd0;
      have_digit <= 1'b0;
      best       <= 7'd0;
      sum        <= '0;
    end else if (close_bank) begin
      max_digit  <= 4'd0;
      have_digit <= 1'b0;
      best       <= 7'd0;
      sum        <= sum + SUM_W'(best_next);
    end else if (accept) begin
      max_digit  <= max_digit_next;
      have_digit <= 1'b1;
      best       <= best_next;
    end
  end

`ifdef PUZZLE3_BANK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bank_cnt <= 16'd0;
    else if (close_bank)
      bank_cnt <= bank_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_puzzle3_1_joltage_acc.sv
// Scoreboard bench for puzzle3_1_joltage_acc; expected sums come from a brute-force pair search per bank.
module tb_puzzle3_1_joltage_acc;

  logic        clk;
  logic        rst_n;
  logic [3:0]  data_in;
  logic        wr_en;
  logic        bank_end;
  logic [31:0] sum;
`ifdef PUZZLE3_BANK_CNT_EN
  logic [15:0] bank_cnt;
  logic [15:0] exp_cnt;
`endif

  logic [31:0] exp_sum;
  logic [31:0] sb_q[$];
  logic [31:0] want;
  int          checks;
  int          passed;

  puzzle3_1_joltage_acc #(.SUM_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .bank_end (bank_end),
`ifdef PUZZLE3_BANK_CNT_EN
    .sum      (sum),
    .bank_cnt (bank_cnt)
`else
    .sum      (sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exhaustive search over every ordered digit pair in the bank.
  function automatic int bank_max(input string s);
    int m;
    int v;
    m = 0;
    for (int i = 0; i < s.len(); i++)
      for (int j = i + 1; j < s.len(); j++) begin
        v = (int'(s[i]) - 48) * 10 + (int'(s[j]) - 48);
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic drive(input logic [3:0] d, input logic we, input logic be);
    @(negedge clk);
    data_in  = d;
    wr_en    = we;
    bank_end = be;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    bank_end = 1'b0;
  endtask

  // Noisy mode slips an idle cycle and an invalid digit, both carrying bank_end, after every digit.
  task automatic send_bank(input string s, input bit terminate, input bit noisy);
    for (int i = 0; i < s.len(); i++) begin
      if (terminate && i == s.len() - 1) begin
        exp_sum = exp_sum + 32'(bank_max(s));
        sb_q.push_back(exp_sum);
`ifdef PUZZLE3_BANK_CNT_EN
        exp_cnt = exp_cnt + 16'd1;
`endif
      end
      drive(4'(int'(s[i]) - 48), 1'b1, terminate && (i == s.len() - 1));
      if (noisy && i != s.len() - 1) begin
        drive(4'd7, 1'b0, 1'b1);
        drive(4'd12, 1'b1, 1'b1);
        drive(4'd15, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic pop_check(input string name);
    checks++;
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, sum=%0d", name, sum);
    end else begin
      want = sb_q.pop_front();
      if (sum !== want)
        $display("[TB] FAIL %s: sum got %0d expected %0d", name, sum, want);
      else
        passed++;
    end
`ifdef PUZZLE3_BANK_CNT_EN
    checks++;
    if (bank_cnt !== exp_cnt)
      $display("[TB] FAIL %s_cnt: bank_cnt got %0d expected %0d", name, bank_cnt, exp_cnt);
    else
      passed++;
`endif
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    data_in  = 4'd0;
    wr_en    = 1'b0;
    bank_end = 1'b0;
    exp_sum  = 32'd0;
`ifdef PUZZLE3_BANK_CNT_EN
    exp_cnt  = 16'd0;
`endif
    #2;
    checks++;
    if (sum !== 32'd0) $display("[TB] FAIL reset_sum: got %0d expected 0", sum);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'd0) $display("[TB] FAIL idle_sum: got %0d expected 0", sum);
    else passed++;
  endtask

  task automatic test_first_bank;
    send_bank("987654321111111", 1'b1, 1'b0);
    pop_check("bank_98");
  endtask

  task automatic test_back_to_back;
    send_bank("811111111111119", 1'b1, 1'b0);
    pop_check("bank_89");
    send_bank("234234234234278", 1'b1, 1'b0);
    pop_check("bank_78");
    send_bank("818181911112111", 1'b1, 1'b0);
    pop_check("bank_92");
    checks++;
    if (sum !== 32'd357) $display("[TB] FAIL total_357: got %0d expected 357", sum);
    else passed++;
  endtask

  task automatic test_single_digit;
    send_bank("5", 1'b1, 1'b0);
    pop_check("single_5");
  endtask

  task automatic test_zero_digit;
    send_bank("09", 1'b1, 1'b0);
    pop_check("bank_09");
    send_bank("90", 1'b1, 1'b0);
    pop_check("bank_90");
    checks++;
    if (sum !== 32'd456) $display("[TB] FAIL total_456: got %0d expected 456", sum);
    else passed++;
  endtask

  task automatic test_ignored_cycles;
    send_bank("818181911112111", 1'b1, 1'b1);
    pop_check("noisy_92");
    send_bank("3", 1'b1, 1'b1);
    pop_check("noisy_single");
  endtask

  task automatic test_async_reset;
    send_bank("987654321111111", 1'b1, 1'b0);
    pop_check("pre_reset_98");
    send_bank("97", 1'b0, 1'b0);
    checks++;
    if (sum !== exp_sum) $display("[TB] FAIL open_bank: got %0d expected %0d", sum, exp_sum);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    exp_sum = 32'd0;
`ifdef PUZZLE3_BANK_CNT_EN
    exp_cnt = 16'd0;
    checks++;
    if (bank_cnt !== 16'd0) $display("[TB] FAIL async_cnt: got %0d expected 0", bank_cnt);
    else passed++;
`endif
    checks++;
    if (sum !== 32'd0) $display("[TB] FAIL async_sum: got %0d expected 0", sum);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    send_bank("12", 1'b1, 1'b0);
    pop_check("post_reset_12");
    checks++;
    if (sum !== 32'd12) $display("[TB] FAIL final_12: got %0d expected 12", sum);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_first_bank();
    test_back_to_back();
    test_single_digit();
    test_zero_digit();
    test_ignored_cycles();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) $display("[TB] FAIL sb_drain: got %0d entries expected 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
